omr_grade_sequencer: RTL and testbench



---
 rtl/omr_grade_sequencer.sv | 159 +++++++++++++++
 tb/tb_omr_grade_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/omr_grade_sequencer.sv
// ============================================================================
// Module   : omr_grade_sequencer
// Brief    : Holds an OMR answer key and grades student sheets one question per
//            cycle, reporting correct/wrong/blank counts and a clamped score.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module omr_grade_sequencer #(
  parameter int NUM_Q       = 10,
  parameter int ANS_W       = 4,
  parameter int CNT_W       = 4,
  parameter int SHEET_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [NUM_Q*ANS_W-1:0]   key_data,
  output logic                     key_ready,
  input  logic                     sheet_valid,
  input  logic [NUM_Q*ANS_W-1:0]   sheet_data,
  output logic                     sheet_ready,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [CNT_W-1:0]         correct_cnt,
  output logic [CNT_W-1:0]         wrong_cnt,
  output logic [CNT_W-1:0]         blank_cnt,
  output logic [CNT_W-1:0]         score,
  output logic [SHEET_CNT_W-1:0]   sheets_graded,
  output logic                     key_loaded,
  output logic                     busy
);

  localparam logic [CNT_W-1:0]       c_last_q  = CNT_W'(NUM_Q - 1);
  localparam logic [CNT_W-1:0]       c_one     = CNT_W'(1);
  localparam logic [SHEET_CNT_W-1:0] c_one_sht = SHEET_CNT_W'(1);

  typedef enum logic [1:0] {
    S_NO_KEY     = 2'd0,
    S_WAIT_SHEET = 2'd1,
    S_GRADE      = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [NUM_Q*ANS_W-1:0]   r_key;
  logic [NUM_Q*ANS_W-1:0]   r_sheet;
  logic [CNT_W-1:0]         r_q_idx;

  logic                     w_key_hs;
  logic                     w_sheet_hs;
  logic                     w_res_hs;
  logic                     w_last;
  logic [ANS_W-1:0]         w_stu;
  logic [ANS_W-1:0]         w_ref;
  logic                     w_blank;
  logic                     w_match;
  logic                     w_miss;
  logic [CNT_W-1:0]         w_correct_nxt;
  logic [CNT_W-1:0]         w_wrong_nxt;
  logic [CNT_W-1:0]         w_blank_nxt;
  logic [CNT_W-1:0]         w_score_nxt;

  // Handshake qualifiers use only state decode for ready/valid, so no input
  // ever reaches a ready or valid output combinationally.
  always_comb begin
    w_state_next = r_state;
    key_ready    = 1'b0;
    sheet_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    w_key_hs     = 1'b0;
    w_sheet_hs   = 1'b0;
    w_res_hs     = 1'b0;
    case (r_state)
      S_NO_KEY: begin
        key_ready = 1'b1;
        w_key_hs  = key_valid;
        if (key_valid) w_state_next = S_WAIT_SHEET;
      end
      S_WAIT_SHEET: begin
        key_ready   = 1'b1;
        sheet_ready = 1'b1;
        w_key_hs    = key_valid;
        w_sheet_hs  = sheet_valid;
        if (sheet_valid) w_state_next = S_GRADE;
      end
      S_GRADE: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        w_res_hs     = result_ready;
        if (result_ready) w_state_next = S_WAIT_SHEET;
      end
      default: w_state_next = S_NO_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_NO_KEY;
    else       r_state <= w_state_next;
  end

  assign w_last  = (r_q_idx == c_last_q);
  assign w_stu   = ANS_W'(r_sheet >> (r_q_idx * ANS_W));
  assign w_ref   = ANS_W'(r_key   >> (r_q_idx * ANS_W));
  assign w_blank = (w_stu == '0);
  assign w_match = !w_blank && (w_stu == w_ref);
  assign w_miss  = !w_blank && (w_stu != w_ref);

  assign w_correct_nxt = correct_cnt + {{(CNT_W-1){1'b0}}, w_match};
  assign w_wrong_nxt   = wrong_cnt   + {{(CNT_W-1){1'b0}}, w_miss};
  assign w_blank_nxt   = blank_cnt   + {{(CNT_W-1){1'b0}}, w_blank};
  assign w_score_nxt   = (w_correct_nxt > w_wrong_nxt) ? (w_correct_nxt - w_wrong_nxt) : '0;

  // Key write and sheet capture are independent, so a simultaneous key and
  // sheet handshake grades the sheet against the new key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key         <= '0;
      r_sheet       <= '0;
      r_q_idx       <= '0;
      key_loaded    <= 1'b0;
      correct_cnt   <= '0;
      wrong_cnt     <= '0;
      blank_cnt     <= '0;
      score         <= '0;
      sheets_graded <= '0;
    end else begin
      if (w_key_hs) begin
        r_key      <= key_data;
        key_loaded <= 1'b1;
      end
      if (w_sheet_hs) begin
        r_sheet     <= sheet_data;
        r_q_idx     <= '0;
        correct_cnt <= '0;
        wrong_cnt   <= '0;
        blank_cnt   <= '0;
        score       <= '0;
      end
      if (r_state == S_GRADE) begin
        correct_cnt <= w_correct_nxt;
        wrong_cnt   <= w_wrong_nxt;
        blank_cnt   <= w_blank_nxt;
        if (w_last) score   <= w_score_nxt;
        else        r_q_idx <= r_q_idx + c_one;
      end
      if (w_res_hs) sheets_graded <= sheets_graded + c_one_sht;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_omr_grade_sequencer.sv
// ============================================================================
// Module   : tb_omr_grade_sequencer
// Brief    : Scoreboard bench for omr_grade_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_omr_grade_sequencer;

  localparam int NUM_Q = 10;
  localparam int ANS_W = 4;
  localparam int CNT_W = 4;
  localparam int SW    = 8;
  localparam int DW    = NUM_Q * ANS_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_valid;
  logic [DW-1:0] key_data;
  logic          key_ready;
  logic          sheet_valid;
  logic [DW-1:0] sheet_data;
  logic          sheet_ready;
  logic          result_valid;
  logic          result_ready;
  logic [CNT_W-1:0] correct_cnt, wrong_cnt, blank_cnt, score;
  logic [SW-1:0] sheets_graded;
  logic          key_loaded;
  logic          busy;

  omr_grade_sequencer #(.NUM_Q(NUM_Q), .ANS_W(ANS_W), .CNT_W(CNT_W), .SHEET_CNT_W(SW)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .sheet_valid(sheet_valid), .sheet_data(sheet_data), .sheet_ready(sheet_ready),
    .result_valid(result_valid), .result_ready(result_ready),
    .correct_cnt(correct_cnt), .wrong_cnt(wrong_cnt), .blank_cnt(blank_cnt),
    .score(score), .sheets_graded(sheets_graded), .key_loaded(key_loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int w;
    int b;
    int s;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            exp_graded = 0;
  logic [DW-1:0] cur_key = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [ANS_W-1:0] code);
    logic [DW-1:0] v = '0;
    for (int i = 0; i < NUM_Q; i++) v = v | (DW'(code) << (i * ANS_W));
    return v;
  endfunction

  function automatic logic [DW-1:0] put(input logic [DW-1:0] v, input int q, input logic [ANS_W-1:0] code);
    logic [DW-1:0] m = DW'({ANS_W{1'b1}}) << (q * ANS_W);
    return (v & ~m) | (DW'(code) << (q * ANS_W));
  endfunction

  function automatic exp_t model(input logic [DW-1:0] k, input logic [DW-1:0] s);
    exp_t e = '{0, 0, 0, 0};
    for (int i = 0; i < NUM_Q; i++) begin
      logic [ANS_W-1:0] st = ANS_W'(s >> (i * ANS_W));
      logic [ANS_W-1:0] kt = ANS_W'(k >> (i * ANS_W));
      if (st == '0)      e.b++;
      else if (st == kt) e.c++;
      else               e.w++;
    end
    e.s = (e.c > e.w) ? e.c - e.w : 0;
    return e;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic load_key(input logic [DW-1:0] k);
    int t = 0;
    while (!key_ready && t < 50) begin @(negedge clk); t++; end
    chk("key_ready_wait", key_ready, 1);
    key_valid = 1'b1; key_data = k;
    @(negedge clk);
    key_valid = 1'b0;
    cur_key = k;
    chk("key_loaded", key_loaded, 1);
  endtask

  task automatic send_sheet(input logic [DW-1:0] s, input bit with_key, input logic [DW-1:0] k);
    int t = 0;
    while (!sheet_ready && t < 50) begin @(negedge clk); t++; end
    chk("sheet_ready_wait", sheet_ready, 1);
    if (with_key) begin
      key_valid = 1'b1; key_data = k; cur_key = k;
    end
    sheet_valid = 1'b1; sheet_data = s;
    sb.push_back(model(cur_key, s));
    @(negedge clk);
    sheet_valid = 1'b0; key_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic collect(input int hold);
    int   lat = 0;
    exp_t e;
    while (!result_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("latency", lat, NUM_Q);
    if (!result_valid || sb.size() == 0) begin
      chk("result_present", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("correct_cnt", correct_cnt, e.c);
    chk("wrong_cnt", wrong_cnt, e.w);
    chk("blank_cnt", blank_cnt, e.b);
    chk("score", score, e.s);
    chk("count_sum", 32'(correct_cnt) + 32'(wrong_cnt) + 32'(blank_cnt), NUM_Q);
    for (int h = 0; h < hold; h++) begin
      sheet_valid = 1'b1; sheet_data = fill(4'b0100);
      @(negedge clk);
      chk("hold_valid", result_valid, 1);
      chk("hold_correct", correct_cnt, e.c);
      chk("hold_score", score, e.s);
      chk("hold_sheet_ready", sheet_ready, 0);
    end
    sheet_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    exp_graded++;
    chk("valid_drop", result_valid, 0);
    chk("sheets_graded", sheets_graded, exp_graded);
    chk("back_to_wait", sheet_ready, 1);
    chk("counts_kept", correct_cnt, e.c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] s;
    logic [ANS_W-1:0] codes [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset = 1'b1; key_valid = 1'b0; key_data = '0; sheet_valid = 1'b0;
    sheet_data = '0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_key_ready", key_ready, 1);
    chk("rst_sheet_ready", sheet_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counts", {correct_cnt, wrong_cnt, blank_cnt, score}, 0);
    chk("rst_graded", sheets_graded, 0);

    // Perfect sheet
    load_key(fill(4'b0001));
    send_sheet(fill(4'b0001), 1'b0, '0);
    collect(0);

    // 6 correct, 3 wrong, 1 blank
    s = fill(4'b0001);
    for (int q = 6; q < 9; q++) s = put(s, q, 4'b0010);
    s = put(s, 9, 4'b0000);
    send_sheet(s, 1'b0, '0);
    collect(0);

    // 2 correct, 7 wrong, 1 blank -> clamped score, with a held result
    s = fill(4'b0010);
    s = put(s, 0, 4'b0001);
    s = put(s, 1, 4'b0001);
    s = put(s, 2, 4'b0000);
    send_sheet(s, 1'b0, '0);
    collect(5);

    // Key and sheet in the same cycle
    send_sheet(fill(4'b1000), 1'b1, fill(4'b1000));
    collect(0);

    // Blank key entry against an answer, plus random sheets
    load_key(put(fill(4'b0100), 3, 4'b0000));
    send_sheet(put(fill(4'b0100), 3, 4'b0010), 1'b0, '0);
    collect(0);
    for (int r = 0; r < 4; r++) begin
      s = '0;
      for (int q = 0; q < NUM_Q; q++) s = put(s, q, codes[$urandom_range(4)]);
      send_sheet(s, 1'b0, '0);
      collect(r % 2);
    end

    // Reset in the middle of grading
    send_sheet(fill(4'b0100), 1'b0, '0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_graded = 0;
    chk("mid_rst_key_loaded", key_loaded, 0);
    chk("mid_rst_result_valid", result_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_counts", {correct_cnt, wrong_cnt, blank_cnt, score}, 0);
    chk("mid_rst_graded", sheets_graded, 0);
    sheet_valid = 1'b1; sheet_data = fill(4'b0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nokey_sheet_ready", sheet_ready, 0);
      chk("nokey_busy", busy, 0);
    end
    sheet_valid = 1'b0;

    // Recovery after reset
    load_key(fill(4'b0010));
    send_sheet(put(fill(4'b0010), 4, 4'b0001), 1'b0, '0);
    collect(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
